cword_assembler: RTL and testbench

- Inverse of the control word field split: packs individual microcode fields into the 32-bit control word.
- Writes the packed word as four bytes into the microcode ROM images: ROM0 main bus, ROM1 ALU, ROM2 address bus, ROM3 misc.
- Sits between the microcode generator (field producer) and the ROM image writer or programmer port.
- Uses a valid/ready handshake on input and a wr_en/wr_ack handshake on output.

---
 rtl/cword_assembler_if.sv | 65 ++++++
 rtl/cword_assembler.sv | 212 +++++++++++++++++++++
 tb/tb_cword_assembler.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cword_assembler_if.sv
`default_nettype none
// ============================================================================
// Module      : cword_assembler_if
// Description : Field-set input handshake and ROM byte-write bus grouped for
//               the control word assembler. The slave modport is the assembler
//               view; the master modport is the producer/writer view.
//               rd_data exists only when CWORD_VERIFY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface cword_assembler_if #(
  parameter int ADDR_W = 12
);
  // producer side
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [3:0]        outctl;
  logic [3:0]        loadctl;
  logic [1:0]        alu_arg_l;
  logic [2:0]        alu_arg_r;
  logic              alu_alt;
  logic              alu_calcfn;
  logic              alu_cin;
  logic [2:0]        addroutctl;
  logic [2:0]        addrloadctl;
  logic              stack_inc;
  logic              stack_dec;
  logic              step_resetn;
  logic              step_extn;
  logic              clk_halt;
  logic              clk_brk;
  logic              acalc_signed;
  // ROM writer side
  logic              wr_en;
  logic              wr_ack;
  logic [1:0]        wr_rom_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
`ifdef CWORD_VERIFY_EN
  logic [7:0]        rd_data;
`endif

  modport slave (
`ifdef CWORD_VERIFY_EN
    input  rd_data,
`endif
    input  in_valid, in_addr, outctl, loadctl, alu_arg_l, alu_arg_r,
           alu_alt, alu_calcfn, alu_cin, addroutctl, addrloadctl,
           stack_inc, stack_dec, step_resetn, step_extn, clk_halt,
           clk_brk, acalc_signed, wr_ack,
    output in_ready, wr_en, wr_rom_sel, wr_addr, wr_data
  );

  modport master (
`ifdef CWORD_VERIFY_EN
    output rd_data,
`endif
    output in_valid, in_addr, outctl, loadctl, alu_arg_l, alu_arg_r,
           alu_alt, alu_calcfn, alu_cin, addroutctl, addrloadctl,
           stack_inc, stack_dec, step_resetn, step_extn, clk_halt,
           clk_brk, acalc_signed, wr_ack,
    input  in_ready, wr_en, wr_rom_sel, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/cword_assembler.sv
`default_nettype none
// ============================================================================
// Module      : cword_assembler
// Description : Packs microcode fields into a 32-bit control word and writes
//               it as four bytes (ROM0 main bus, ROM1 ALU, ROM2 address bus,
//               ROM3 misc) over a wr_en/wr_ack handshake.
//               Optional readback verification: define CWORD_VERIFY_EN to add
//               a CHK cycle after every acked byte comparing rd_data.
// Revision    : 1.0 - initial release
// ============================================================================
module cword_assembler #(
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cword_assembler_if.slave     bus,
  output logic [31:0]          cword_o,
  output logic                 done_o,
  output logic                 err_conflict_o
`ifdef CWORD_VERIFY_EN
  ,
  output logic                 verify_err_o
`endif
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    WR0  = 4'd1,
    WR1  = 4'd2,
    WR2  = 4'd3,
    WR3  = 4'd4
`ifdef CWORD_VERIFY_EN
    ,
    CHK0 = 4'd5,
    CHK1 = 4'd6,
    CHK2 = 4'd7,
    CHK3 = 4'd8
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [1:0]        rom_sel_q, rom_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [31:0]       cword_q, cword_d;
  logic              done_q, done_d;
  logic              err_conflict_q, err_conflict_d;
`ifdef CWORD_VERIFY_EN
  logic              verify_err_q, verify_err_d;
`endif

  logic [31:0]       w_packed;
  logic [1:0]        w_next_sel;
  logic              w_advance;

  // Field layout of the control word; the top three bits are reserved zero.
  assign w_packed = {3'b000,
                     bus.acalc_signed, bus.clk_brk, bus.clk_halt,
                     bus.step_extn, bus.step_resetn,
                     bus.stack_dec, bus.stack_inc,
                     bus.addrloadctl, bus.addroutctl,
                     bus.alu_cin, bus.alu_calcfn, bus.alu_alt,
                     bus.alu_arg_r, bus.alu_arg_l,
                     bus.loadctl, bus.outctl};

  assign w_next_sel = rom_sel_q + 2'd1;

  function automatic state_t wr_of(input logic [1:0] sel);
    case (sel)
      2'd1:    return WR1;
      2'd2:    return WR2;
      2'd3:    return WR3;
      default: return WR0;
    endcase
  endfunction

`ifdef CWORD_VERIFY_EN
  function automatic state_t chk_of(input state_t s);
    case (s)
      WR0:     return CHK0;
      WR1:     return CHK1;
      WR2:     return CHK2;
      default: return CHK3;
    endcase
  endfunction
`endif

  // Next-state and output decode; w_advance marks a finished byte so the
  // step to the next byte (or to done) is shared by WR and CHK paths.
  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    wr_en_d        = wr_en_q;
    rom_sel_d      = rom_sel_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    cword_d        = cword_q;
    done_d         = 1'b0;
    err_conflict_d = 1'b0;
`ifdef CWORD_VERIFY_EN
    verify_err_d   = 1'b0;
`endif
    w_advance      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          if (bus.stack_inc && bus.stack_dec) begin
            // simultaneous push and pop is illegal microcode; drop it
            err_conflict_d = 1'b1;
          end else begin
            cword_d    = w_packed;
            wr_addr_d  = bus.in_addr;
            rom_sel_d  = 2'd0;
            wr_data_d  = w_packed[7:0];
            wr_en_d    = 1'b1;
            in_ready_d = 1'b0;
            state_d    = WR0;
          end
        end
      end
      WR0, WR1, WR2, WR3: begin
        if (bus.wr_ack) begin
`ifdef CWORD_VERIFY_EN
          wr_en_d = 1'b0;
          state_d = chk_of(state_q);
`else
          w_advance = 1'b1;
`endif
        end
      end
`ifdef CWORD_VERIFY_EN
      CHK0, CHK1, CHK2, CHK3: begin
        if (bus.rd_data == wr_data_q) begin
          w_advance = 1'b1;
        end else begin
          verify_err_d = 1'b1;
          in_ready_d   = 1'b1;
          state_d      = IDLE;
        end
      end
`endif
      default: begin
        wr_en_d    = 1'b0;
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
    endcase

    if (w_advance) begin
      if (rom_sel_q == 2'd3) begin
        wr_en_d    = 1'b0;
        done_d     = 1'b1;
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end else begin
        rom_sel_d = w_next_sel;
        wr_data_d = cword_q[{w_next_sel, 3'b000} +: 8];
        wr_en_d   = 1'b1;
        state_d   = wr_of(w_next_sel);
      end
    end
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b1;
      wr_en_q        <= 1'b0;
      rom_sel_q      <= 2'd0;
      wr_addr_q      <= '0;
      wr_data_q      <= 8'h00;
      cword_q        <= 32'h0;
      done_q         <= 1'b0;
      err_conflict_q <= 1'b0;
`ifdef CWORD_VERIFY_EN
      verify_err_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      wr_en_q        <= wr_en_d;
      rom_sel_q      <= rom_sel_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      cword_q        <= cword_d;
      done_q         <= done_d;
      err_conflict_q <= err_conflict_d;
`ifdef CWORD_VERIFY_EN
      verify_err_q   <= verify_err_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_rom_sel = rom_sel_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign cword_o        = cword_q;
  assign done_o         = done_q;
  assign err_conflict_o = err_conflict_q;
`ifdef CWORD_VERIFY_EN
  assign verify_err_o   = verify_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cword_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cword_assembler
// Description : Self-checking bench for cword_assembler: a word-level model
//               tracks which byte must be on the bus, directed scenarios pin
//               literal values, and a randomized phase exercises handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cword_assembler;
  localparam int ADDR_W = 12;
`ifdef CWORD_VERIFY_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 4;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cword_assembler_if #(.ADDR_W(ADDR_W)) bus ();
  logic [31:0] cword_o;
  logic        done_o;
  logic        err_conflict_o;
`ifdef CWORD_VERIFY_EN
  logic        verify_err_o;
`endif

  cword_assembler #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .cword_o        (cword_o),
    .done_o         (done_o),
    .err_conflict_o (err_conflict_o)
`ifdef CWORD_VERIFY_EN
    ,
    .verify_err_o   (verify_err_o)
`endif
  );

  typedef struct {
    logic [3:0] outctl; logic [3:0] loadctl; logic [1:0] arg_l; logic [2:0] arg_r;
    logic alt; logic calcfn; logic cin; logic [2:0] aout; logic [2:0] aload;
    logic inc; logic dec; logic resetn; logic extn; logic halt; logic brk; logic sgn;
    logic [ADDR_W-1:0] addr;
  } fields_t;

  typedef struct { int sel; int addr; int data; } wr_t;

  int  checks = 0;
  int  fails  = 0;
  bit  cmp_en = 1'b0;
  wr_t log_q[$];
  logic [7:0] exp_b [4] = '{8'h53, 8'hB6, 8'h4E, 8'h13};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word value from the field rules, as a sum of shifted fields.
  function automatic logic [31:0] model_pack(input fields_t f);
    int w;
    w = int'(f.outctl) + (int'(f.loadctl) << 4) + (int'(f.arg_l) << 8)
      + (int'(f.arg_r) << 10) + (int'(f.alt) << 13) + (int'(f.calcfn) << 14)
      + (int'(f.cin) << 15) + (int'(f.aout) << 16) + (int'(f.aload) << 19)
      + (int'(f.inc) << 22) + (int'(f.dec) << 23) + (int'(f.resetn) << 24)
      + (int'(f.extn) << 25) + (int'(f.halt) << 26) + (int'(f.brk) << 27)
      + (int'(f.sgn) << 28);
    return w;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return 8'((w >> (8 * k)) & 32'hFF);
  endfunction

  function automatic fields_t tv();
    fields_t f;
    f.outctl = 4'd3; f.loadctl = 4'd5; f.arg_l = 2'd2; f.arg_r = 3'd5;
    f.alt = 1'b1; f.calcfn = 1'b0; f.cin = 1'b1; f.aout = 3'd6; f.aload = 3'd1;
    f.inc = 1'b1; f.dec = 1'b0; f.resetn = 1'b1; f.extn = 1'b1; f.halt = 1'b0;
    f.brk = 1'b0; f.sgn = 1'b1; f.addr = 12'h2A5;
    return f;
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f.outctl = 4'($urandom); f.loadctl = 4'($urandom); f.arg_l = 2'($urandom);
    f.arg_r = 3'($urandom); f.alt = 1'($urandom); f.calcfn = 1'($urandom);
    f.cin = 1'($urandom); f.aout = 3'($urandom); f.aload = 3'($urandom);
    f.inc = ($urandom % 3 == 0); f.dec = ($urandom % 3 == 0);
    f.resetn = 1'($urandom); f.extn = 1'($urandom); f.halt = 1'($urandom);
    f.brk = 1'($urandom); f.sgn = 1'($urandom); f.addr = ADDR_W'($urandom);
    return f;
  endfunction

  task automatic drive(input fields_t f);
    bus.outctl = f.outctl; bus.loadctl = f.loadctl; bus.alu_arg_l = f.arg_l;
    bus.alu_arg_r = f.arg_r; bus.alu_alt = f.alt; bus.alu_calcfn = f.calcfn;
    bus.alu_cin = f.cin; bus.addroutctl = f.aout; bus.addrloadctl = f.aload;
    bus.stack_inc = f.inc; bus.stack_dec = f.dec; bus.step_resetn = f.resetn;
    bus.step_extn = f.extn; bus.clk_halt = f.halt; bus.clk_brk = f.brk;
    bus.acalc_signed = f.sgn; bus.in_addr = f.addr;
  endtask

  function automatic fields_t sample_bus();
    fields_t f;
    f.outctl = bus.outctl; f.loadctl = bus.loadctl; f.arg_l = bus.alu_arg_l;
    f.arg_r = bus.alu_arg_r; f.alt = bus.alu_alt; f.calcfn = bus.alu_calcfn;
    f.cin = bus.alu_cin; f.aout = bus.addroutctl; f.aload = bus.addrloadctl;
    f.inc = bus.stack_inc; f.dec = bus.stack_dec; f.resetn = bus.step_resetn;
    f.extn = bus.step_extn; f.halt = bus.clk_halt; f.brk = bus.clk_brk;
    f.sgn = bus.acalc_signed; f.addr = bus.in_addr;
    return f;
  endfunction

`ifdef CWORD_VERIFY_EN
  int corrupt_sel = -1;
  bit rd_noise    = 1'b0;
  // ROM readback: echoes the presented byte unless a fault is injected.
  always @* bus.rd_data = ((int'(bus.wr_rom_sel) == corrupt_sel) || rd_noise) ? 8'h00 : bus.wr_data;
`endif

  // Reference model: busy flag, byte index, optional check phase.
  bit          m_busy = 1'b0, m_chk = 1'b0, m_done = 1'b0, m_err = 1'b0, m_verr = 1'b0;
  int          m_k = 0;
  logic [31:0] m_cword = 32'h0;
  logic [ADDR_W-1:0] m_addr = '0;

  always @(posedge clk or negedge rst_n) begin : model_p
    fields_t f;
    bit adv;
    if (!rst_n) begin
      m_busy = 1'b0; m_chk = 1'b0; m_k = 0; m_cword = 32'h0; m_addr = '0;
      m_done = 1'b0; m_err = 1'b0; m_verr = 1'b0;
    end else begin
      adv = 1'b0;
      m_done = 1'b0; m_err = 1'b0; m_verr = 1'b0;
      if (!m_busy) begin
        if (bus.in_valid === 1'b1) begin
          f = sample_bus();
          if (f.inc && f.dec) m_err = 1'b1;
          else begin
            m_cword = model_pack(f); m_addr = f.addr; m_k = 0; m_busy = 1'b1; m_chk = 1'b0;
          end
        end
      end else if (!m_chk) begin
        if (bus.wr_ack === 1'b1) begin
`ifdef CWORD_VERIFY_EN
          m_chk = 1'b1;
`else
          adv = 1'b1;
`endif
        end
      end else begin
`ifdef CWORD_VERIFY_EN
        if (bus.rd_data == byte_of(m_cword, m_k)) adv = 1'b1;
        else begin m_verr = 1'b1; m_busy = 1'b0; m_chk = 1'b0; end
`endif
      end
      if (adv) begin
        m_chk = 1'b0;
        if (m_k == 3) begin m_busy = 1'b0; m_done = 1'b1; end
        else m_k++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", 32'(bus.in_ready), 32'(!m_busy));
      check("wr_en", 32'(bus.wr_en), 32'(m_busy && !m_chk));
      check("done", 32'(done_o), 32'(m_done));
      check("err_conflict", 32'(err_conflict_o), 32'(m_err));
      check("cword", cword_o, m_cword);
`ifdef CWORD_VERIFY_EN
      check("verify_err", 32'(verify_err_o), 32'(m_verr));
`endif
      if (m_busy && !m_chk) begin
        check("wr_rom_sel", 32'(bus.wr_rom_sel), 32'(m_k));
        check("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
        check("wr_data", 32'(bus.wr_data), 32'(byte_of(m_cword, m_k)));
      end
    end
  end

  // Log of every acked byte write.
  always @(posedge clk) begin : log_p
    wr_t e;
    if (rst_n && bus.wr_en === 1'b1 && bus.wr_ack === 1'b1) begin
      e.sel = int'(bus.wr_rom_sel); e.addr = int'(bus.wr_addr); e.data = int'(bus.wr_data);
      log_q.push_back(e);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(output int n, input int bound);
    n = 0;
    while (done_o !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    check("done_seen", 32'(done_o), 32'd1);
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  endtask

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    finish_run();
  end

  initial begin : main_p
    fields_t f, fa, fb, z;
    int n, dn;
    bit saw;
    z = '{default: '0};
    drive(z);
    bus.in_valid = 1'b0;
    bus.wr_ack   = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    cmp_en = 1'b1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_rom_sel", 32'(bus.wr_rom_sel), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_cword", cword_o, 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_conflict_o), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    step();
    check("model_pack_tv", model_pack(tv()), 32'h134EB653);
    check("model_byte1_tv", 32'(byte_of(model_pack(tv()), 1)), 32'hB6);

    // directed word with wr_ack tied high
    log_q.delete();
    bus.wr_ack = 1'b1; drive(tv()); bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("t1_wr_en_after_accept", 32'(bus.wr_en), 32'd1);
    wait_done(n, 40);
    check("t1_done_latency", 32'(n), 32'(LAT));
    check("t1_cword", cword_o, 32'h134EB653);
    check("t1_write_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      check("t1_sel", 32'(log_q[i].sel), 32'(i));
      check("t1_addr", 32'(log_q[i].addr), 32'h2A5);
      check("t1_data", 32'(log_q[i].data), 32'(exp_b[i]));
    end
    step();
    check("t1_done_one_cycle", 32'(done_o), 32'd0);

    // delayed acknowledge: outputs must hold while waiting
    log_q.delete();
    bus.wr_ack = 1'b0; drive(tv()); bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      repeat (3) begin
        check("t2_sel_hold", 32'(bus.wr_rom_sel), 32'(b));
        check("t2_data_hold", 32'(bus.wr_data), 32'(exp_b[b]));
        check("t2_wr_en_hold", 32'(bus.wr_en), 32'd1);
        check("t2_in_ready_low", 32'(bus.in_ready), 32'd0);
        step();
      end
      bus.wr_ack = 1'b1; step(); bus.wr_ack = 1'b0;
`ifdef CWORD_VERIFY_EN
      step();
`endif
    end
    check("t2_done", 32'(done_o), 32'd1);
    check("t2_write_count", 32'(log_q.size()), 32'd4);

    // stack_inc and stack_dec together are rejected
    f = tv(); f.inc = 1'b1; f.dec = 1'b1; f.outctl = 4'hF;
    drive(f); bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("t3_err_pulse", 32'(err_conflict_o), 32'd1);
    check("t3_no_wr_en", 32'(bus.wr_en), 32'd0);
    check("t3_in_ready", 32'(bus.in_ready), 32'd1);
    check("t3_cword_kept", cword_o, 32'h134EB653);
    step();
    check("t3_err_one_cycle", 32'(err_conflict_o), 32'd0);

    // reset while byte 2 is pending
    log_q.delete();
    f = rand_fields(); f.dec = 1'b0;
    drive(f); bus.in_valid = 1'b1; bus.wr_ack = 1'b0;
    step();
    bus.in_valid = 1'b0;
    repeat (2) begin
      bus.wr_ack = 1'b1; step(); bus.wr_ack = 1'b0;
`ifdef CWORD_VERIFY_EN
      step();
`endif
    end
    check("t4_in_wr2", 32'(bus.wr_rom_sel), 32'd2);
    check("t4_wr_en_before", 32'(bus.wr_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t4_wr_en_async_drop", 32'(bus.wr_en), 32'd0);
    step(); step();
    rst_n = 1'b1;
    check("t4_writes_before_reset", 32'(log_q.size()), 32'd2);
    check("t4_no_done", 32'(done_o), 32'd0);
    f = rand_fields(); f.dec = 1'b0;
    drive(f); bus.in_valid = 1'b1; bus.wr_ack = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_done(n, 40);
    check("t4_latency_after_reset", 32'(n), 32'(LAT));
    check("t4_write_count", 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 4 && i + 2 < log_q.size(); i++) begin
      check("t4_sel", 32'(log_q[i+2].sel), 32'(i));
      check("t4_data", 32'(log_q[i+2].data), 32'(byte_of(model_pack(f), i)));
      check("t4_addr", 32'(log_q[i+2].addr), 32'(f.addr));
    end

    // back-to-back words with in_valid held high
    log_q.delete();
    fa = rand_fields(); fa.dec = 1'b0;
    fb = rand_fields(); fb.dec = 1'b0;
    drive(fa); bus.in_valid = 1'b1; bus.wr_ack = 1'b1;
    step();
    drive(fb);
    wait_done(n, 40);
    check("t5_in_ready_done_cycle", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("t5_second_accepted", 32'(bus.wr_en), 32'd1);
    wait_done(n, 40);
    check("t5_write_count", 32'(log_q.size()), 32'd8);
    if (log_q.size() == 8) begin
      check("t5_first_last", 32'(log_q[3].data), 32'(byte_of(model_pack(fa), 3)));
      check("t5_second_first", 32'(log_q[4].data), 32'(byte_of(model_pack(fb), 0)));
      check("t5_second_last", 32'(log_q[7].data), 32'(byte_of(model_pack(fb), 3)));
    end
    step();

`ifdef CWORD_VERIFY_EN
    // readback mismatch on ROM1 byte
    log_q.delete();
    corrupt_sel = 1;
    drive(tv()); bus.in_valid = 1'b1; bus.wr_ack = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n = 0; saw = 1'b0;
    while (verify_err_o !== 1'b1 && n < 40) begin
      step(); n++;
      if (done_o === 1'b1) saw = 1'b1;
    end
    check("t6_verify_err", 32'(verify_err_o), 32'd1);
    check("t6_no_done_before", 32'(saw), 32'd0);
    check("t6_write_count", 32'(log_q.size()), 32'd2);
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("t6_no_done_after", 32'(done_o), 32'd0);
    corrupt_sel = -1;
`endif

    // randomized traffic
    dn = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 3 == 0) drive(rand_fields());
      bus.in_valid = 1'($urandom);
      bus.wr_ack   = 1'($urandom);
`ifdef CWORD_VERIFY_EN
      rd_noise = ($urandom % 12 == 0);
`endif
      if ($urandom % 600 == 0) begin
        rst_n = 1'b0; #1 rst_n = 1'b1;
      end
      step();
      if (done_o === 1'b1) dn++;
    end
    bus.in_valid = 1'b0; bus.wr_ack = 1'b1;
`ifdef CWORD_VERIFY_EN
    rd_noise = 1'b0;
`endif
    repeat (20) step();
    check("rand_done_seen", 32'(dn > 0), 32'd1);
    check("rand_idle_at_end", 32'(bus.in_ready), 32'd1);
    finish_run();
  end

endmodule
`default_nettype wire
